// File: rtl/mouse_tracker_if.sv
// -----------------------------------------------------------------------------
// mouse_tracker_if
//   Groups the PS/2 pin pair and the decoded cursor outputs of mouse_tracker.
//   master : the PS/2 device side / consumer (drives pins, reads cursor)
//   slave  : mouse_tracker itself (reads pins, drives cursor)
// Signals:
//   ps2_clk, ps2_data      raw PS/2 pins, asynchronous to the system clock
//   xpos, ypos [8:0]       absolute cursor position, unsigned
//   leftclick              left-button level from the last accepted packet
//   packet_valid           one-cycle pulse when a packet is applied
//   frame_err              one-cycle pulse on a rejected frame or timeout
// -----------------------------------------------------------------------------
interface mouse_tracker_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [8:0] xpos;
  logic [8:0] ypos;
  logic       leftclick;
  logic       packet_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  xpos, ypos, leftclick, packet_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output xpos, ypos, leftclick, packet_valid, frame_err
  );
endinterface

// File: rtl/mouse_tracker.sv
// -----------------------------------------------------------------------------
// mouse_tracker
//   Decodes standard 3-byte PS/2 mouse movement packets and integrates them
//   into a clamped 9-bit absolute cursor position plus left-button level.
// Ports:
//   clk    system clock (only clock in the block)
//   reset  asynchronous, active-low reset
//   bus    mouse_tracker_if.slave: ps2_clk/ps2_data in; xpos, ypos,
//          leftclick, packet_valid, frame_err out (all outputs registered)
// -----------------------------------------------------------------------------
module mouse_tracker #(
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 319,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 239,
  parameter int X_INIT  = 160,
  parameter int Y_INIT  = 120,
  parameter int TIMEOUT = 50000
) (
  input logic            clk,
  input logic            reset,
  mouse_tracker_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

  // SHIFT takes the 8 data bits and the parity bit; CHECK waits for the stop
  // bit and validates the frame on that same edge so a completed packet is
  // visible on the very next cycle.
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK
  } state_e;

  // Only the byte0 fields that matter are kept.
  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic left;
  } hdr_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and falling-edge detect
  // ---------------------------------------------------------------------------
  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic dat_s1_q, dat_s2_q;
  logic fall;

  // NOTE: the synchronizers reset to 1 (idle bus) so releasing reset while
  // the pins are idle never fabricates a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= bus.ps2_clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= bus.ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fall = clk_s3_q & ~clk_s2_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [8:0]      sr_q, sr_d;          // {parity, data[7:0]} after 9 shifts
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [1:0]      idx_q, idx_d;
  hdr_t            hdr_q, hdr_d;
  logic [7:0]      byte1_q, byte1_d;
  logic [8:0]      xpos_q, xpos_d;
  logic [8:0]      ypos_q, ypos_d;
  logic            left_q, left_d;
  logic            pv_q, pv_d;
  logic            fe_q, fe_d;

  logic            byte_ok;
  logic [7:0]      rx_byte;
  logic signed [10:0] dx, dy, nx, ny;

  function automatic logic [8:0] clamp(input logic signed [10:0] v,
                                       input logic signed [10:0] lo,
                                       input logic signed [10:0] hi);
    if (v < lo)      return lo[8:0];
    else if (v > hi) return hi[8:0];
    else             return v[8:0];
  endfunction

  // Packet arithmetic: byte2 is the live received byte when index is 2.
  assign rx_byte = sr_q[7:0];
  assign dx = {{3{hdr_q.x_sign}}, byte1_q};
  assign dy = {{3{hdr_q.y_sign}}, rx_byte};
  assign nx = $signed({2'b00, xpos_q}) + dx;
  // PS/2 y points up, screen y points down.
  assign ny = $signed({2'b00, ypos_q}) - dy;

  // NOTE: every signal assigned here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    to_cnt_d  = to_cnt_q;
    idx_d     = idx_q;
    hdr_d     = hdr_q;
    byte1_d   = byte1_q;
    xpos_d    = xpos_q;
    ypos_d    = ypos_q;
    left_d    = left_q;
    pv_d      = 1'b0;
    fe_d      = 1'b0;
    byte_ok   = 1'b0;

    // Byte receiver
    case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (fall) begin
          if (!dat_s2_q) begin
            state_d   = S_SHIFT;
            bit_cnt_d = '0;
          end else begin
            fe_d = 1'b1;          // bad start bit
          end
        end
      end
      S_SHIFT: begin
        if (fall) begin
          sr_d      = {dat_s2_q, sr_q[8:1]};   // LSB first
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (fall) begin
          state_d = S_IDLE;
          // Odd parity over data+parity, and stop must be 1.
          if ((^sr_q) && dat_s2_q) begin
            byte_ok = 1'b1;
          end else begin
            fe_d  = 1'b1;
            idx_d = 2'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame timeout: a falling edge always wins over the terminal count.
    if (state_q != S_IDLE) begin
      if (fall) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TW'(TIMEOUT)) begin
        fe_d     = 1'b1;
        state_d  = S_IDLE;
        idx_d    = 2'd0;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    // Packet assembler
    if (byte_ok) begin
      case (idx_q)
        2'd0: begin
          // bit3 is always 1 in a header byte; anything else is misaligned.
          if (rx_byte[3]) begin
            hdr_d = '{y_ovf: rx_byte[7], x_ovf: rx_byte[6], y_sign: rx_byte[5],
                      x_sign: rx_byte[4], left: rx_byte[0]};
            idx_d = 2'd1;
          end
        end
        2'd1: begin
          byte1_d = rx_byte;
          idx_d   = 2'd2;
        end
        default: begin
          idx_d  = 2'd0;
          pv_d   = 1'b1;
          left_d = hdr_q.left;
          if (!hdr_q.x_ovf) xpos_d = clamp(nx, X_MIN_S, X_MAX_S);
          if (!hdr_q.y_ovf) ypos_d = clamp(ny, Y_MIN_S, Y_MAX_S);
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      to_cnt_q  <= '0;
      idx_q     <= 2'd0;
      hdr_q     <= '0;
      byte1_q   <= '0;
      xpos_q    <= 9'(X_INIT);
      ypos_q    <= 9'(Y_INIT);
      left_q    <= 1'b0;
      pv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      to_cnt_q  <= to_cnt_d;
      idx_q     <= idx_d;
      hdr_q     <= hdr_d;
      byte1_q   <= byte1_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      left_q    <= left_d;
      pv_q      <= pv_d;
      fe_q      <= fe_d;
    end
  end

  assign bus.xpos         = xpos_q;
  assign bus.ypos         = ypos_q;
  assign bus.leftclick    = left_q;
  assign bus.packet_valid = pv_q;
  assign bus.frame_err    = fe_q;

endmodule

// File: tb/tb_mouse_tracker.sv
// -----------------------------------------------------------------------------
// tb_mouse_tracker
//   Directed PS/2 traffic with hand-computed cursor results. Stimulus pushes
//   the expected event (packet or frame error) into a queue; a monitor pops
//   and compares whenever the DUT pulses packet_valid or frame_err.
// -----------------------------------------------------------------------------
module tb_mouse_tracker;

  localparam int TO = 200;   // short timeout keeps the run brief

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mouse_tracker_if bus ();

  mouse_tracker #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       is_err;
    logic [8:0] x;
    logic [8:0] y;
    logic       l;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (bus.packet_valid || bus.frame_err)) begin
      check("event_was_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("event_frame_err", int'(bus.frame_err), int'(e.is_err));
        check("event_packet_valid", int'(bus.packet_valid), int'(!e.is_err));
        if (!e.is_err) begin
          check("xpos", int'(bus.xpos), int'(e.x));
          check("ypos", int'(bus.ypos), int'(e.y));
          check("leftclick", int'(bus.leftclick), int'(e.l));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (4) @(posedge clk);
    bus.ps2_clk = 1'b0;
    repeat (8) @(posedge clk);
    bus.ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // Sends the first nbits of a frame (11 = complete frame).
  task automatic send_byte(input logic [7:0] d, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, ~(^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    bus.ps2_data = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic expect_pkt(input logic [8:0] x, input logic [8:0] y, input logic l);
    ev_t e;
    e.is_err = 1'b0; e.x = x; e.y = y; e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    ev_t e;
    e.is_err = 1'b1; e.x = '0; e.y = '0; e.l = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [8:0] x, input logic [8:0] y, input logic l);
    expect_pkt(x, y, l);
    send_byte(b0, 1'b0, 11);
    send_byte(b1, 1'b0, 11);
    send_byte(b2, 1'b0, 11);
  endtask

  task automatic check_outputs(input string tag, input int x, input int y, input int l);
    @(negedge clk);
    check({tag, "_xpos"}, int'(bus.xpos), x);
    check({tag, "_ypos"}, int'(bus.ypos), y);
    check({tag, "_left"}, int'(bus.leftclick), l);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    check_outputs("reset", 160, 120, 0);
    check("reset_pv", int'(bus.packet_valid), 0);
    check("reset_fe", int'(bus.frame_err), 0);

    // Reset mid-byte, then a clean packet
    send_byte(8'h09, 1'b0, 5);
    pulse_reset();
    check_outputs("mid_reset", 160, 120, 0);
    send_packet(8'h09, 8'h05, 8'h03, 165, 117, 1'b1);

    // Negative motion and clamps
    pulse_reset();
    send_packet(8'h18, 8'h80, 8'h00,  32, 120, 1'b0);
    send_packet(8'h18, 8'h80, 8'h00,   0, 120, 1'b0);
    send_packet(8'h08, 8'h00, 8'h7F,   0,   0, 1'b0);
    send_packet(8'h08, 8'h00, 8'h7F,   0,   0, 1'b0);
    send_packet(8'h28, 8'h00, 8'h80,   0, 128, 1'b0);
    send_packet(8'h28, 8'h00, 8'h80,   0, 239, 1'b0);

    // Parity error on byte1, outputs unchanged, then realignment
    expect_err();
    send_byte(8'h09, 1'b0, 11);
    send_byte(8'h05, 1'b1, 11);
    check_outputs("after_parity", 0, 239, 0);
    send_packet(8'h09, 8'h05, 8'h03, 5, 236, 1'b1);

    // Stray misaligned byte is dropped silently
    send_byte(8'h00, 1'b0, 11);
    send_packet(8'h08, 8'h0A, 8'h02, 15, 234, 1'b0);

    // Start bit of 1 is a frame error
    expect_err();
    ps2_bit(1'b1);
    bus.ps2_data = 1'b1;
    repeat (20) @(posedge clk);
    check_outputs("after_start_err", 15, 234, 0);

    // X overflow holds xpos
    pulse_reset();
    send_packet(8'h49, 8'h10, 8'h10, 160, 104, 1'b1);

    // Timeout mid-frame, then a normal packet
    expect_err();
    send_byte(8'h09, 1'b0, 4);
    repeat (TO + 20) @(posedge clk);
    check_outputs("after_timeout", 160, 104, 1);
    send_packet(8'h09, 8'h05, 8'h03, 165, 101, 1'b1);

    repeat (50) @(posedge clk);
    check("leftover_expects", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mouse_tracker.md
# mouse_tracker

Upstream stage of the drawing-input path. Receives raw PS/2 mouse traffic on the ps2_clk/ps2_data pins and decodes standard 3-byte movement packets. Integrates the movement into a clamped 9-bit absolute cursor position and reports the left-button level. Its xpos/ypos/leftclick outputs drive the pixel-grid decoder directly.

## Interface
Parameters:
- X_MIN, default 0: lowest legal xpos.
- X_MAX, default 319: highest legal xpos.
- Y_MIN, default 0: lowest legal ypos.
- Y_MAX, default 239: highest legal ypos.
- X_INIT, default 160: xpos after reset.
- Y_INIT, default 120: ypos after reset.
- TIMEOUT, default 50000: clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted.

Ports:
- clk  in  1  system clock; the only clock in the block.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock from the pin, asynchronous.
- ps2_data  in  1  raw PS/2 data from the pin, asynchronous.
- xpos  out  9  cursor x position, unsigned.
- ypos  out  9  cursor y position, unsigned; increases downward.
- leftclick  out  1  left-button level from the last accepted packet.
- packet_valid  out  1  one-cycle pulse when a packet is applied.
- frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- **Input synchronization:** ps2_clk and ps2_data each pass through 2 flops. A third flop on ps2_clk gives falling-edge detection. Data is sampled on the detected falling edge.
- **Byte receiver FSM: IDLE -> SHIFT -> CHECK.**
  - IDLE waits for a falling edge with data=0 (the start bit). A start bit of 1 gives frame_err and stays in IDLE.
  - SHIFT collects 8 data bits LSB-first, then the parity bit, then the stop bit: 10 further edges.
  - CHECK requires odd parity over the 8 data bits plus the parity bit, and stop=1. Pass: the byte goes to the packet assembler. Fail: frame_err, byte discarded, packet index reset to 0. Then back to IDLE.
- **Timeout:** a counter clears on every falling edge and counts while not in IDLE. When it reaches TIMEOUT: frame_err, receiver to IDLE, packet index to 0.
- **Packet assembler:** the index runs 0 -> 1 -> 2 -> 0.
  - At index 0, a byte with bit3=0 is dropped as misaligned. No error pulse, index stays 0.
  - Byte0 fields: bit0 left, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
  - dx = signed 9-bit {Xsign, byte1}; dy = signed 9-bit {Ysign, byte2}.
- **Position update on packet completion:**
  - nx = xpos + dx, computed 11-bit signed.
  - ny = ypos - dy, computed 11-bit signed. The PS/2 y axis points up; the screen y axis points down.
  - Each result clamps to [X_MIN, X_MAX] and [Y_MIN, Y_MAX].
  - If the X overflow bit is set, xpos is held. The Y overflow bit holds ypos the same way.
  - leftclick takes byte0 bit0 on every accepted packet, including overflow packets.
- **Reset:** a reset asserted at any time, including mid-byte or mid-packet, gives the following values.
  - xpos=X_INIT, ypos=Y_INIT.
  - leftclick=0, packet_valid=0, frame_err=0.
  - FSM in IDLE, packet index 0, timeout counter 0, synchronizer flops 1 (bus idle).
- Host-to-device commands are not supported. The mouse must already be in stream mode.

## Timing
- Falling-edge detect fires 3 clk cycles after the pin edge, because of the synchronizer plus the edge flop.
- The stop bit of byte2 is detected in cycle N. In cycle N+1, xpos/ypos/leftclick show their new values and packet_valid=1. packet_valid is high for exactly 1 cycle.
- frame_err is a 1-cycle pulse in the cycle after the failing check or the timeout terminal count.
- A packet error and a packet completion cannot coincide: they happen on different bytes.
- A timeout in the same cycle as a falling edge: the edge wins and the counter clears.
- Outputs are registered and change only on packet_valid or reset.
- Minimum clk is 8x the PS/2 clock rate, i.e. 8x 16.7 kHz.

## Test plan
- **Reset mid-byte:** drive 5 bits of a frame, pulse reset low. Expect xpos=160, ypos=120, leftclick=0. A following clean packet {0x09, 0x05, 0x03} gives xpos=165, ypos=117, leftclick=1, with one packet_valid pulse.
- **Negative motion and clamp:** start at x=160. Send {0x18, 0x80, 0x00}: dx=-128, no Y motion, bit3=1. Expect xpos=32. Repeat the packet and expect xpos=0, clamped to X_MIN. Send dy=+0x7F repeatedly from y=120 and expect ypos to saturate at 0. Send dy=-0x80 repeatedly and expect 239.
- **Parity error:** corrupt the parity of byte1. Expect a frame_err pulse, no packet_valid, and outputs unchanged. The next clean 3-byte packet is applied correctly, showing realignment.
- **Misalignment:** send a stray 0x00 first, then a valid packet. The stray byte is silently dropped, and exactly one packet_valid follows.
- **Overflow:** send {0x49, 0x10, 0x10}, which has X overflow set. Expect xpos held, ypos=104 (from 120), leftclick=1.
- **Timeout:** stop ps2_clk after 4 bits for TIMEOUT+1 cycles. Expect one frame_err pulse. The next full packet decodes normally.
